// File: rtl/rggen_irq_pkg.sv
// Shared types for the interrupt coalescer: FSM state encoding and event-count sizing.
package rggen_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIRE    = 2'd2
  } irq_state_e;

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/rggen_irq_coalescer_if.sv
// Bundle of the coalescer's enable/status inputs and irq/busy/count outputs.
interface rggen_irq_coalescer_if #(
  parameter int WIDTH = 8
);
  import rggen_irq_pkg::*;

  logic             enable;
  logic [WIDTH-1:0] status;
  logic             irq;
  logic [CNT_W-1:0] event_count;
  logic             busy;

  // master drives the status side, slave is the coalescer itself
  modport master (
    output enable,
    output status,
    input  irq,
    input  event_count,
    input  busy
  );

  modport slave (
    input  enable,
    input  status,
    output irq,
    output event_count,
    output busy
  );

endinterface

// File: rtl/rggen_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module rggen_popcount #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] i_bits,
  output logic [CW-1:0]    o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/rggen_irq_coalescer.sv
// Interrupt coalescer: counts rising status bits and fires one irq after THRESHOLD
// events or TIMEOUT cycles since the first event; i_enable=0 bypasses coalescing.
module rggen_irq_coalescer
  import rggen_irq_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int THRESHOLD = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [WIDTH-1:0] i_status,
  output logic             o_irq,
  output logic [CNT_W-1:0] o_event_count,
  output logic             o_busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  // sum width wide enough that neither operand nor the carry can overflow
  localparam int SW = ((CW > CNT_W) ? CW : CNT_W) + 1;

  irq_state_e       state_q, state_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             irq_q, irq_d;

  logic [WIDTH-1:0] new_bits;
  logic [CW-1:0]    n_new;
  logic [SW-1:0]    n_new_w;
  logic [SW-1:0]    sum_w;
  logic [CNT_W-1:0] n_new_sat;
  logic [CNT_W-1:0] sum_sat;

  assign new_bits = i_status & ~status_q;

  rggen_popcount #(
    .WIDTH (WIDTH)
  ) u_popcount (
    .i_bits  (new_bits),
    .o_count (n_new)
  );

  always_comb begin
    n_new_w   = SW'(n_new);
    sum_w     = SW'(count_q) + n_new_w;
    n_new_sat = (n_new_w > SW'(CNT_MAX)) ? CNT_MAX : n_new_w[CNT_W-1:0];
    sum_sat   = (sum_w   > SW'(CNT_MAX)) ? CNT_MAX : sum_w[CNT_W-1:0];
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    timer_d  = timer_q;
    status_d = i_status;
    if (!i_enable) begin
      state_d = IDLE;
      count_d = '0;
      timer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          count_d = '0;
          timer_d = '0;
          if (n_new_w != '0) begin
            count_d = n_new_sat;
            state_d = (n_new_w >= SW'(THRESHOLD)) ? FIRE : COLLECT;
          end
        end
        COLLECT: begin
          // an all-clear status closes the window even if it would also fire
          if (i_status == '0) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
          end else begin
            count_d = sum_sat;
            // timer stops at TIMEOUT at most, which fits TW bits without wrapping
            timer_d = timer_q + TW'(1);
            if ((sum_sat >= CNT_W'(THRESHOLD)) || (timer_q == TW'(TIMEOUT - 1))) begin
              state_d = FIRE;
            end
          end
        end
        FIRE: begin
          if (i_status == '0) begin
            state_d = IDLE;
            count_d = '0;
            timer_d = '0;
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          timer_d = '0;
        end
      endcase
    end
    irq_d = (state_d == FIRE) | (!i_enable & (|i_status));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      status_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      irq_q    <= irq_d;
    end
  end

  assign o_irq         = irq_q;
  assign o_event_count = count_q;
  assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_rggen_irq_coalescer.sv
// Bench for rggen_irq_coalescer: two parameterisations driven with the same
// directed and random status traffic, checked against a window/event model.
module tb_rggen_irq_coalescer;

  logic clk;
  logic rst;

  rggen_irq_coalescer_if #(.WIDTH(8)) bus0 ();
  rggen_irq_coalescer_if #(.WIDTH(8)) bus1 ();

  rggen_irq_coalescer #(.WIDTH(8), .THRESHOLD(4), .TIMEOUT(16)) dut0 (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (bus0.enable),
    .i_status      (bus0.status),
    .o_irq         (bus0.irq),
    .o_event_count (bus0.event_count),
    .o_busy        (bus0.busy)
  );

  rggen_irq_coalescer #(.WIDTH(8), .THRESHOLD(3), .TIMEOUT(1)) dut1 (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (bus1.enable),
    .i_status      (bus1.status),
    .o_irq         (bus1.irq),
    .o_event_count (bus1.event_count),
    .o_busy        (bus1.busy)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard counters and per-DUT expectations
  int unsigned total = 0;
  int unsigned bad   = 0;

  int          th [2] = '{4, 3};
  int          to [2] = '{16, 1};
  bit          m_win   [2];
  bit          m_fired [2];
  int          m_events[2];
  int          m_age   [2];
  bit          m_irq   [2];
  logic [7:0]  m_prev;
  logic [7:0]  cur_st;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: a window opens on the first new event, fires on enough events or age,
  // and only an all-zero status (or disable/reset) closes it.
  task automatic model_step(input bit r, input bit en, input logic [7:0] st);
    int n;
    n = $countones(st & ~m_prev);
    for (int k = 0; k < 2; k++) begin
      if (r || !en) begin
        m_win[k] = 0; m_fired[k] = 0; m_events[k] = 0; m_age[k] = 0;
        m_irq[k] = !r && (st != 0);
      end else begin
        if (m_fired[k]) begin
          if (st == 0) begin m_fired[k] = 0; m_events[k] = 0; end
        end else if (m_win[k]) begin
          if (st == 0) begin
            m_win[k] = 0; m_events[k] = 0; m_age[k] = 0;
          end else begin
            m_events[k] = (m_events[k] + n > 255) ? 255 : m_events[k] + n;
            if (m_events[k] >= th[k] || m_age[k] == to[k] - 1) begin
              m_win[k] = 0; m_fired[k] = 1;
            end
            m_age[k]++;
          end
        end else if (n > 0) begin
          m_events[k] = (n > 255) ? 255 : n;
          m_age[k] = 0;
          if (n >= th[k]) m_fired[k] = 1;
          else            m_win[k]   = 1;
        end
        m_irq[k] = m_fired[k];
      end
    end
    m_prev = r ? 8'h00 : st;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq0"},   32'(bus0.irq),         32'(m_irq[0]));
    check({tag, ".busy0"},  32'(bus0.busy),        32'(m_win[0] | m_fired[0]));
    check({tag, ".count0"}, 32'(bus0.event_count), m_events[0]);
    check({tag, ".irq1"},   32'(bus1.irq),         32'(m_irq[1]));
    check({tag, ".busy1"},  32'(bus1.busy),        32'(m_win[1] | m_fired[1]));
    check({tag, ".count1"}, 32'(bus1.event_count), m_events[1]);
  endtask

  // driver: apply one cycle of inputs, advance past the edge, compare
  task automatic cycle(input string tag, input bit r, input bit en, input logic [7:0] st);
    rst = r;
    bus0.enable = en; bus0.status = st;
    bus1.enable = en; bus1.status = st;
    cur_st = st;
    model_step(r, en, st);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1;
    bus0.enable = 1'b1; bus0.status = 8'h00;
    bus1.enable = 1'b1; bus1.status = 8'h00;
    m_prev = 8'h00;
    cur_st = 8'h00;
    for (int k = 0; k < 2; k++) begin
      m_win[k] = 0; m_fired[k] = 0; m_events[k] = 0; m_age[k] = 0; m_irq[k] = 0;
    end
    @(posedge clk); #1;

    // reset state
    cycle("reset", 1'b1, 1'b1, 8'h00);
    check("reset_irq", 32'(bus0.irq), 0);
    check("reset_busy", 32'(bus0.busy), 0);
    cycle("idle", 1'b0, 1'b1, 8'h00);

    // timeout: bit0 rises in cycle 0, irq in cycle 17
    for (int i = 0; i <= 16; i++) begin
      cycle("timeout", 1'b0, 1'b1, 8'h01);
      if (i == 0) begin
        check("to_busy_c1", 32'(bus0.busy), 1);
        check("to1_busy_c1", 32'(bus1.busy), 1);
        check("to1_irq_c1", 32'(bus1.irq), 0);
      end
      if (i == 1)  check("to1_irq_c2", 32'(bus1.irq), 1);
      if (i == 15) check("to_irq_c16", 32'(bus0.irq), 0);
      if (i == 16) begin
        check("to_irq_c17", 32'(bus0.irq), 1);
        check("to_count_c17", 32'(bus0.event_count), 1);
      end
    end
    cycle("to_clr", 1'b0, 1'b1, 8'h00);

    // threshold: four bits at once, cleared at cycle 5
    cycle("thr", 1'b0, 1'b1, 8'h0F);
    check("thr_irq_c1", 32'(bus0.irq), 1);
    for (int i = 1; i <= 4; i++) cycle("thr_hold", 1'b0, 1'b1, 8'h0F);
    cycle("thr_clr", 1'b0, 1'b1, 8'h00);
    check("thr_irq_c6", 32'(bus0.irq), 0);
    check("thr_busy_c6", 32'(bus0.busy), 0);
    check("thr_count_c6", 32'(bus0.event_count), 0);

    // early clear before threshold/timeout
    for (int i = 0; i < 3; i++) begin
      cycle("early", 1'b0, 1'b1, 8'h01);
      check("early_noirq", 32'(bus0.irq), 0);
    end
    cycle("early_clr", 1'b0, 1'b1, 8'h00);
    check("early_busy_c4", 32'(bus0.busy), 0);
    check("early_noirq_c4", 32'(bus0.irq), 0);

    // accumulate one bit per cycle, then re-rise a bit while firing
    cycle("acc0", 1'b0, 1'b1, 8'h01);
    cycle("acc1", 1'b0, 1'b1, 8'h03);
    cycle("acc2", 1'b0, 1'b1, 8'h07);
    check("acc_noirq_c3", 32'(bus0.irq), 0);
    cycle("acc3", 1'b0, 1'b1, 8'h0F);
    check("acc_irq_c4", 32'(bus0.irq), 1);
    check("acc_count_c4", 32'(bus0.event_count), 4);
    cycle("acc_fall", 1'b0, 1'b1, 8'h0E);
    cycle("acc_rerise", 1'b0, 1'b1, 8'h0F);
    check("acc_count_held", 32'(bus0.event_count), 4);
    cycle("acc_clr", 1'b0, 1'b1, 8'h00);

    // bypass, then disable mid-window
    cycle("byp", 1'b0, 1'b0, 8'h10);
    check("byp_irq_c1", 32'(bus0.irq), 1);
    cycle("byp_win", 1'b0, 1'b1, 8'h11);
    check("byp_win_busy", 32'(bus0.busy), 1);
    cycle("byp_dis", 1'b0, 1'b0, 8'h11);
    cycle("byp_en", 1'b0, 1'b1, 8'h11);
    check("byp_count0", 32'(bus0.event_count), 0);
    check("byp_busy0", 32'(bus0.busy), 0);
    cycle("byp_clr", 1'b0, 1'b1, 8'h00);

    // reset mid-window with two events counted
    cycle("rst_a", 1'b0, 1'b1, 8'h01);
    cycle("rst_b", 1'b0, 1'b1, 8'h03);
    check("rst_count2", 32'(bus0.event_count), 2);
    cycle("rst_pulse", 1'b1, 1'b1, 8'h03);
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_count", 32'(bus0.event_count), 0);
    cycle("rst_after", 1'b0, 1'b1, 8'h03);
    check("rst_recount", 32'(bus0.event_count), 2);
    cycle("rst_clr", 1'b0, 1'b1, 8'h00);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      logic [7:0] st;
      int unsigned r;
      st = cur_st;
      r = $urandom_range(0, 9);
      if (r == 0)      st = 8'h00;
      else if (r < 5)  st = st ^ (8'h01 << $urandom_range(0, 7));
      cycle("rand", ($urandom_range(0, 99) == 0), ($urandom_range(0, 19) != 0), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
